adc16dv160_input_capture: RTL and testbench
===========================================

ADC16DV160_INPUT_CAPTURE -- requirements
Module: adc16dv160_input_capture

Interface
REQ-001 SHALL have ports: ACLK  in  1  sole clock; ARESETN  in  1  asynchronous active-low reset.
REQ-002 SHALL have ports: adc_data  in  16  signed two's-complement ADC sample; adc_valid  in  1  sample strobe.
REQ-003 SHALL have control inputs from the register block: dsize  in  32  frame length in samples; cr_start  in  1  single-cycle start pulse; cr_test  in  1  test-pattern mode; cr_rt  in  1  continuous (real-time) mode; cr_ls  in  1  level-sync mode.
REQ-004 SHALL have level-sync inputs: ls_start_thr  in  16  signed start threshold; ls_stop_thr  in  16  signed stop threshold; ls_n_start  in  32  start run length; ls_n_stop  in  32  stop run length.
REQ-005 SHALL have stream outputs: M_AXIS_TDATA  out  16  sample; M_AXIS_TVALID  out  1; M_AXIS_TLAST  out  1  last sample of frame; M_AXIS_TREADY  in  1.
REQ-006 SHALL have status outputs: busy  out  1  not in IDLE; overflow  out  1  sticky sample-drop flag.

Function
REQ-007 SHALL implement states IDLE, ARM, CAPTURE, FLUSH.
REQ-008 IDLE: cr_start=1 with dsize!=0 -> ARM if cr_ls=1, else CAPTURE; cr_start with dsize=0 ignored; cr_start outside IDLE ignored.
REQ-009 Capture sample source: adc_data when cr_test=0; 16-bit test counter when cr_test=1, counter cleared on leaving IDLE, +1 per adc_valid, wraps 0xFFFF->0x0000.
REQ-010 ARM: run counter +1 on each adc_valid with source >= ls_start_thr (signed), cleared on adc_valid below it; transition to CAPTURE when count reaches max(ls_n_start,1); the completing sample is the frame's first sample.
REQ-011 CAPTURE: each adc_valid sample is stored in the output register and counted by a 32-bit frame counter.
REQ-012 Frame ends on the sample where frame count = dsize; that sample carries TLAST=1.
REQ-013 If cr_ls=1 and ls_n_stop!=0: a stop run counter counts consecutive samples < ls_stop_thr (signed); the sample bringing it to ls_n_stop ends the frame with TLAST=1, even if count < dsize.
REQ-014 Frame end -> FLUSH; FLUSH waits until the output register empties (TVALID=0 or TVALID&TREADY), then -> IDLE if cr_rt=0, else ARM (cr_ls=1) or CAPTURE (cr_ls=0) with frame and run counters cleared.
REQ-015 cr_rt sampled at frame end only; clearing cr_rt mid-frame completes the current frame, then IDLE.
REQ-016 Output register: single stage; TVALID set when loaded, cleared on TVALID&TREADY without a new load same cycle; load and drain in one cycle is allowed.
REQ-017 TDATA/TLAST SHALL hold stable while TVALID=1 and TREADY=0.
REQ-018 adc_valid in CAPTURE while TVALID=1 and TREADY=0: sample dropped, overflow set, sample still counted (frame length preserved in time).
REQ-019 If the dropped sample is the TLAST sample, TLAST SHALL be forced onto the held word.
REQ-020 overflow cleared only by cr_start accepted in IDLE or by reset.
REQ-021 Samples arriving in IDLE or FLUSH SHALL be discarded without setting overflow.
REQ-022 Latency: sample with adc_valid in cycle N appears on TDATA with TVALID in cycle N+1.
REQ-023 Counters 32-bit unsigned, no wrap within a frame (dsize <= 2^32-1).

Reset
REQ-024 ARESETN=0 SHALL asynchronously force: state IDLE, TVALID=0, TLAST=0, TDATA=0, busy=0, overflow=0, all counters 0.
REQ-025 Reset mid-frame SHALL abandon the frame with no TLAST emitted; first post-reset frame requires a new cr_start.

Verification
REQ-026 dsize=4, cr_ls=0, TREADY=1, adc_data 10,11,12,13,14 -> 4 beats 10..13, TLAST on 13, busy low after FLUSH, 14 discarded.
REQ-027 cr_ls=1, ls_start_thr=100, ls_n_start=3, data 50,120,130,90,110,120,130,5 -> frame starts at second 130 (third consecutive >=100).
REQ-028 cr_ls=1, dsize=100, ls_stop_thr=0, ls_n_stop=2, data after trigger 5,-1,3,-2,-3 -> frame 5,-1,3,-2,-3 with TLAST on -3.
REQ-029 dsize=3, TREADY=0 for 3 samples -> one held beat, overflow=1, TLAST forced on held word; new cr_start clears overflow.
REQ-030 cr_rt=1, cr_test=1, dsize=2 -> frames 0,1 / 0,1 repeating (counter restarts per frame); clear cr_rt mid-frame -> current frame completes, then IDLE.
REQ-031 ARESETN low mid-CAPTURE -> immediately TVALID=0, busy=0, overflow=0; no TLAST emitted.

Source files
------------

// File: rtl/adc16dv160_input_capture.sv
// ADC sample capture into a single-stage AXI-Stream output register with frame
// length control, optional level-sync start/stop, test counter and real-time re-arm.
module adc16dv160_input_capture (
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic [15:0] adc_data,
    input  logic        adc_valid,
    input  logic [31:0] dsize,
    input  logic        cr_start,
    input  logic        cr_test,
    input  logic        cr_rt,
    input  logic        cr_ls,
    input  logic [15:0] ls_start_thr,
    input  logic [15:0] ls_stop_thr,
    input  logic [31:0] ls_n_start,
    input  logic [31:0] ls_n_stop,
    output logic [15:0] M_AXIS_TDATA,
    output logic        M_AXIS_TVALID,
    output logic        M_AXIS_TLAST,
    input  logic        M_AXIS_TREADY,
    output logic        busy,
    output logic        overflow
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FLUSH   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic [31:0] run_q, run_d;
    logic [31:0] srun_q, srun_d;
    logic [31:0] fcnt_q, fcnt_d;
    logic [15:0] tdata_q, tdata_d;
    logic        tvalid_q, tvalid_d;
    logic        tlast_q, tlast_d;
    logic        ovf_q, ovf_d;
    logic        rt_q, rt_d;

    logic [15:0] src_s;
    logic        drain_s;
    logic        room_s;
    logic        above_start_s;
    logic        below_stop_s;
    logic        stop_en_s;
    logic        last_s;
    logic        take_s;
    logic [31:0] n_start_s;
    logic [31:0] run_inc_s;
    logic [31:0] fcnt_inc_s;
    logic [31:0] srun_inc_s;

    // Per-sample source selection and framing decisions
    always_comb begin
        src_s         = cr_test ? tcnt_q : adc_data;
        drain_s       = tvalid_q & M_AXIS_TREADY;
        room_s        = ~tvalid_q | M_AXIS_TREADY;
        above_start_s = $signed(src_s) >= $signed(ls_start_thr);
        below_stop_s  = $signed(src_s) < $signed(ls_stop_thr);
        stop_en_s     = cr_ls & (ls_n_stop != 32'd0);
        n_start_s     = (ls_n_start == 32'd0) ? 32'd1 : ls_n_start;
        run_inc_s     = run_q + 32'd1;
        fcnt_inc_s    = fcnt_q + 32'd1;
        if (stop_en_s && below_stop_s) begin
            srun_inc_s = srun_q + 32'd1;
        end else begin
            srun_inc_s = 32'd0;
        end
        last_s = (fcnt_inc_s == dsize) |
                 (stop_en_s & below_stop_s & (srun_inc_s == ls_n_stop));
    end

    // Next-state, counters and output register
    always_comb begin
        state_d  = state_q;
        tcnt_d   = tcnt_q;
        run_d    = run_q;
        srun_d   = srun_q;
        fcnt_d   = fcnt_q;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q;
        tlast_d  = tlast_q;
        ovf_d    = ovf_q;
        rt_d     = rt_q;
        take_s   = 1'b0;

        if (drain_s) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
        end else begin
            tvalid_d = tvalid_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cr_start && (dsize != 32'd0)) begin
                    state_d = cr_ls ? ST_ARM : ST_CAPTURE;
                    ovf_d   = 1'b0;
                    tcnt_d  = 16'd0;
                    run_d   = 32'd0;
                    srun_d  = 32'd0;
                    fcnt_d  = 32'd0;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (adc_valid) begin
                    tcnt_d = tcnt_q + 16'd1;
                    if (above_start_s) begin
                        run_d = run_inc_s;
                        if (run_inc_s == n_start_s) begin
                            state_d = ST_CAPTURE;
                            take_s  = 1'b1;
                        end else begin
                            take_s = 1'b0;
                        end
                    end else begin
                        run_d = 32'd0;
                    end
                end else begin
                    take_s = 1'b0;
                end
            end
            ST_CAPTURE: begin
                if (adc_valid) begin
                    tcnt_d = tcnt_q + 16'd1;
                    take_s = 1'b1;
                end else begin
                    take_s = 1'b0;
                end
            end
            ST_FLUSH: begin
                // Re-entry clears the test counter so each real-time frame restarts at 0
                if (room_s) begin
                    if (rt_q) begin
                        state_d = cr_ls ? ST_ARM : ST_CAPTURE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                    tcnt_d = 16'd0;
                    run_d  = 32'd0;
                    srun_d = 32'd0;
                    fcnt_d = 32'd0;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take_s) begin
            fcnt_d = fcnt_inc_s;
            srun_d = srun_inc_s;
            if (room_s) begin
                tdata_d  = src_s;
                tlast_d  = last_s;
                tvalid_d = 1'b1;
            end else begin
                // Dropped sample: keep the held word, but never lose the frame end
                ovf_d = 1'b1;
                if (last_s) begin
                    tlast_d = 1'b1;
                end else begin
                    tlast_d = tlast_q;
                end
            end
            if (last_s) begin
                state_d = ST_FLUSH;
                rt_d    = cr_rt;
            end else begin
                rt_d = rt_q;
            end
        end else begin
            rt_d = rt_q;
        end
    end

    // State and datapath registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ST_IDLE;
            tcnt_q   <= 16'd0;
            run_q    <= 32'd0;
            srun_q   <= 32'd0;
            fcnt_q   <= 32'd0;
            tdata_q  <= 16'd0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            ovf_q    <= 1'b0;
            rt_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            run_q    <= run_d;
            srun_q   <= srun_d;
            fcnt_q   <= fcnt_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            ovf_q    <= ovf_d;
            rt_q     <= rt_d;
        end
    end

    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign busy          = (state_q != ST_IDLE);
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_adc16dv160_input_capture.sv
// Scoreboard bench: stimulus pushes expected beats, a monitor pops them on each
// accepted stream beat; random frames are checked against a sequence-level model.
module tb_adc16dv160_input_capture;

    logic               ACLK = 1'b0;
    logic               ARESETN;
    logic [15:0]        adc_data;
    logic               adc_valid;
    logic [31:0]        dsize;
    logic               cr_start, cr_test, cr_rt, cr_ls;
    logic signed [15:0] ls_start_thr, ls_stop_thr;
    logic [31:0]        ls_n_start, ls_n_stop;
    logic [15:0]        M_AXIS_TDATA;
    logic               M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TREADY;
    logic               busy, overflow;

    int errors = 0;
    int checks = 0;
    logic [16:0]        exp_q[$];
    logic signed [15:0] stim_q[$];
    logic [16:0]        mon_e;
    bit                 frame_done;

    adc16dv160_input_capture dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .dsize(dsize), .cr_start(cr_start), .cr_test(cr_test), .cr_rt(cr_rt), .cr_ls(cr_ls),
        .ls_start_thr(ls_start_thr), .ls_stop_thr(ls_stop_thr),
        .ls_n_start(ls_n_start), .ls_n_stop(ls_n_stop),
        .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
        .busy(busy), .overflow(overflow)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic send(input logic [15:0] d, input int gap);
        adc_data  = d;
        adc_valid = 1'b1;
        tick();
        adc_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic start_pulse();
        cr_start = 1'b1;
        tick();
        cr_start = 1'b0;
    endtask

    task automatic push(input logic last, input logic [15:0] d);
        exp_q.push_back({last, d});
    endtask

    task automatic do_reset();
        ARESETN = 1'b0;
        tick();
        ARESETN = 1'b1;
        tick();
    endtask

    // Sequence-level reference: find the trigger point, then cut the frame by length or stop run
    task automatic model_frame(output bit done);
        int k, run, start, cnt, srun;
        bit last;
        logic signed [15:0] v;
        done  = 1'b0;
        start = -1;
        k     = (ls_n_start == 32'd0) ? 1 : int'(ls_n_start);
        if (!cr_ls) begin
            if (stim_q.size() > 0) start = 0;
        end else begin
            run = 0;
            for (int i = 0; i < stim_q.size() && start < 0; i++) begin
                if (stim_q[i] >= ls_start_thr) run++;
                else run = 0;
                if (run == k) start = i;
            end
        end
        if (start >= 0) begin
            cnt  = 0;
            srun = 0;
            for (int i = start; i < stim_q.size() && !done; i++) begin
                v = stim_q[i];
                cnt++;
                if (cr_ls && ls_n_stop != 32'd0 && v < ls_stop_thr) srun++;
                else srun = 0;
                last = (cnt == int'(dsize)) ||
                       (cr_ls && ls_n_stop != 32'd0 && srun == int'(ls_n_stop));
                exp_q.push_back({last, v});
                done = last;
            end
        end
    endtask

    // Monitor: every accepted beat must match the head of the scoreboard
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESETN === 1'b1 && M_AXIS_TVALID === 1'b1 && M_AXIS_TREADY === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL beat: unexpected data=%0h last=%0b, required no beat",
                             M_AXIS_TDATA, M_AXIS_TLAST);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat", {15'd0, M_AXIS_TLAST, M_AXIS_TDATA}, {15'd0, mon_e});
                end
            end
        end
    end

    initial begin
        ARESETN = 1'b0;
        adc_data = 16'd0; adc_valid = 1'b0; dsize = 32'd4;
        cr_start = 1'b0; cr_test = 1'b0; cr_rt = 1'b0; cr_ls = 1'b0;
        ls_start_thr = 16'sd0; ls_stop_thr = 16'sd0; ls_n_start = 32'd0; ls_n_stop = 32'd0;
        M_AXIS_TREADY = 1'b1;
        repeat (2) tick();
        chk("rst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        chk("rst_tlast", {31'd0, M_AXIS_TLAST}, 32'd0);
        chk("rst_tdata", {16'd0, M_AXIS_TDATA}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        ARESETN = 1'b1;
        tick();

        // Start with zero frame length is ignored
        dsize = 32'd0;
        start_pulse();
        tick();
        chk("dsize0_busy", {31'd0, busy}, 32'd0);

        // Plain frame of four, fifth sample discarded
        dsize = 32'd4;
        start_pulse();
        chk("basic_busy", {31'd0, busy}, 32'd1);
        push(1'b0, 16'd10); push(1'b0, 16'd11); push(1'b0, 16'd12); push(1'b1, 16'd13);
        for (int i = 10; i <= 14; i++) send(16'(i), 0);
        repeat (3) tick();
        chk("basic_idle", {31'd0, busy}, 32'd0);
        chk("basic_drain", exp_q.size(), 32'd0);

        // Level-sync start: third consecutive sample >= 100 opens the frame
        cr_ls = 1'b1; dsize = 32'd3; ls_start_thr = 16'sd100; ls_n_start = 32'd3; ls_n_stop = 32'd0;
        start_pulse();
        push(1'b0, 16'd130); push(1'b0, 16'd5); push(1'b1, 16'd7);
        send(16'd50, 0); send(16'd120, 0); send(16'd130, 0); send(16'd90, 0);
        send(16'd110, 0); send(16'd120, 0); send(16'd130, 0); send(16'd5, 0); send(16'd7, 0);
        repeat (3) tick();
        chk("lsstart_idle", {31'd0, busy}, 32'd0);
        chk("lsstart_drain", exp_q.size(), 32'd0);

        // Level-sync stop: two consecutive samples below 0 end the frame early
        dsize = 32'd100; ls_start_thr = 16'sd1; ls_n_start = 32'd1;
        ls_stop_thr = 16'sd0; ls_n_stop = 32'd2;
        start_pulse();
        push(1'b0, 16'd5); push(1'b0, 16'hFFFF); push(1'b0, 16'd3);
        push(1'b0, 16'hFFFE); push(1'b1, 16'hFFFD);
        send(16'd5, 0); send(16'hFFFF, 0); send(16'd3, 0);
        send(16'hFFFE, 0); send(16'hFFFD, 0); send(16'd8, 0);
        repeat (3) tick();
        chk("lsstop_idle", {31'd0, busy}, 32'd0);
        chk("lsstop_drain", exp_q.size(), 32'd0);

        // Backpressure: drops set overflow and force TLAST onto the held word
        cr_ls = 1'b0; ls_n_stop = 32'd0; dsize = 32'd3; M_AXIS_TREADY = 1'b0;
        start_pulse();
        send(16'd21, 0); send(16'd22, 0); send(16'd23, 0);
        chk("ovf_tdata", {16'd0, M_AXIS_TDATA}, 32'd21);
        chk("ovf_tlast", {31'd0, M_AXIS_TLAST}, 32'd1);
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_busy", {31'd0, busy}, 32'd1);
        push(1'b1, 16'd21);
        M_AXIS_TREADY = 1'b1;
        repeat (2) tick();
        chk("ovf_idle", {31'd0, busy}, 32'd0);
        chk("ovf_sticky", {31'd0, overflow}, 32'd1);
        start_pulse();
        chk("ovf_cleared", {31'd0, overflow}, 32'd0);
        push(1'b0, 16'd1); push(1'b0, 16'd2); push(1'b1, 16'd3);
        send(16'd1, 0); send(16'd2, 0); send(16'd3, 0);
        repeat (3) tick();
        chk("ovf_drain", exp_q.size(), 32'd0);

        // Real-time test-pattern frames, then clearing cr_rt finishes the current frame
        cr_rt = 1'b1; cr_test = 1'b1; dsize = 32'd2;
        start_pulse();
        for (int f = 0; f < 4; f++) begin
            push(1'b0, 16'd0); push(1'b1, 16'd1);
        end
        for (int s = 0; s < 7; s++) send(16'(16'hABCD + s), 2);
        cr_rt = 1'b0;
        send(16'h5555, 2);
        send(16'h6666, 2); send(16'h7777, 2);
        chk("rt_idle", {31'd0, busy}, 32'd0);
        chk("rt_drain", exp_q.size(), 32'd0);
        cr_test = 1'b0;

        // Asynchronous reset mid-capture abandons the frame
        dsize = 32'd10; M_AXIS_TREADY = 1'b0;
        start_pulse();
        send(16'd1, 0); send(16'd2, 0);
        chk("arst_pre_ovf", {31'd0, overflow}, 32'd1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("arst_tvalid", {31'd0, M_AXIS_TVALID}, 32'd0);
        chk("arst_busy", {31'd0, busy}, 32'd0);
        chk("arst_ovf", {31'd0, overflow}, 32'd0);
        chk("arst_tlast", {31'd0, M_AXIS_TLAST}, 32'd0);
        tick();
        ARESETN = 1'b1;
        M_AXIS_TREADY = 1'b1;
        repeat (3) tick();
        send(16'd5, 0); send(16'd6, 0);
        repeat (2) tick();
        chk("arst_nostart", {31'd0, busy}, 32'd0);

        // Randomized frames against the reference model
        for (int it = 0; it < 25; it++) begin
            cr_ls        = 1'($urandom_range(0, 1));
            dsize        = 32'($urandom_range(1, 10));
            ls_start_thr = 16'(int'($urandom_range(0, 40)) - 20);
            ls_stop_thr  = 16'(int'($urandom_range(0, 40)) - 20);
            ls_n_start   = 32'($urandom_range(0, 3));
            ls_n_stop    = 32'($urandom_range(0, 3));
            stim_q.delete();
            for (int i = 0; i < 24; i++) stim_q.push_back(16'(int'($urandom_range(0, 200)) - 100));
            model_frame(frame_done);
            start_pulse();
            for (int i = 0; i < stim_q.size(); i++) send(stim_q[i], int'($urandom_range(0, 2)));
            repeat (4) tick();
            chk("rand_busy", {31'd0, busy}, {31'd0, ~frame_done});
            chk("rand_ovf", {31'd0, overflow}, 32'd0);
            chk("rand_drain", exp_q.size(), 32'd0);
            if (!frame_done) do_reset();
        end

        chk("sb_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
